// File: rtl/apb_master_pkg.sv
// Shared APB requester types: FSM state encoding, command bundle and defaults.
package apb_states;

    localparam int APB_ADDR_W          = 4;
    localparam int APB_DATA_W          = 8;
    localparam int APB_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the cycle on which the transfer must abort.
// expired is combinational so the FSM can leave ACCESS on the TIMEOUT-th stalled cycle.
module apb_wait_timer
    import apb_states::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Wait-state counter: restarts on ACCESS entry, advances on every stalled ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick && (TIMEOUT != 0)) begin
            count <= count + 1'b1;
        end
    end

    // The stalled cycle that would bring the count to TIMEOUT is the abort cycle.
    assign expired = (TIMEOUT != 0) && tick && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: takes single commands on a valid/ready port, runs them through
// IDLE->SETUP->ACCESS and returns a one-cycle response pulse. A wait-state timer
// aborts transfers whose slave never raises PREADY.
module apb_master
    import apb_states::*;
#(
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    apb_state_t state;
    logic       timer_clear;
    logic       timer_tick;
    logic       timer_expired;

    // Only IDLE can take a command; a reset cycle never consumes one.
    assign cmd_ready   = (state == IDLE) && !PRESET;
    assign timer_clear = (state == SETUP);
    assign timer_tick  = (state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    // Protocol FSM with registered APB and response outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PSELx   <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a simultaneous timeout.
                    if (PREADY) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        state     <= IDLE;
                    end else if (timer_expired) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    PSELx   <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: slave model with programmable wait states, scoreboard of
// expected responses, plus a second instance with the timeout disabled.
module tb_apb_master;
    import apb_states::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       PRESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       PSELx, PENABLE, PWRITE, PREADY;
    logic [3:0] PADDR;
    logic [7:0] PWDATA, PRDATA;

    logic       c0_valid = 1'b0;
    logic       c0_ready, r0_valid, r0_err;
    logic [7:0] r0_rdata;
    logic       psel0, penable0, pwrite0;
    logic       pready0 = 1'b0;
    logic [3:0] paddr0;
    logic [7:0] pwdata0;
    logic [7:0] prdata0 = 8'h5C;

    always #5 clk = ~clk;

    apb_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TO)) dut (
        .PCLK(clk), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    apb_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(0)) dut0 (
        .PCLK(clk), .PRESET(PRESET),
        .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_write(1'b0),
        .cmd_addr(4'h9), .cmd_wdata(8'h00),
        .rsp_valid(r0_valid), .rsp_rdata(r0_rdata), .rsp_err(r0_err),
        .PSELx(psel0), .PENABLE(penable0), .PWRITE(pwrite0), .PADDR(paddr0),
        .PWDATA(pwdata0), .PREADY(pready0), .PRDATA(prdata0)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [7:0] mem [16];
    logic [7:0] exp_mem [16];
    int         wait_n = 0;
    logic       stuck = 1'b0;
    int         acc_cnt = 0;

    assign PREADY = PSELx && PENABLE && !stuck && (acc_cnt >= wait_n);
    assign PRDATA = mem[PADDR];

    always @(posedge clk) begin
        if (PSELx && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (PSELx && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t     exp_q[$];
    apb_cmd_t cur_cmd = '0;
    int       push_cnt = 0;
    int       rsp_cnt = 0;
    int       acc_seen = 0;
    int       bus_bad = 0;
    int       cyc = 0;
    int       accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (PSELx && PENABLE) acc_seen++;
        if (PSELx && (PADDR !== cur_cmd.addr || PWRITE !== cur_cmd.write ||
                      (cur_cmd.write && PWDATA !== cur_cmd.wdata)))
            bus_bad++;
        if (rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Drive one command and push its expected response once it is accepted.
    task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d,
                         input int wn, input logic st, input bit hold);
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        wait_n = wn; stuck = st;
        @(posedge clk);
        accept_cyc = cyc;
        cur_cmd.write = w; cur_cmd.addr = a; cur_cmd.wdata = d;
        e.err   = st || (wn >= TO);
        e.rdata = (w || e.err) ? 8'h00 : exp_mem[a];
        if (w && !e.err) exp_mem[a] = d;
        exp_q.push_back(e);
        push_cnt++;
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("rsp_missing", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        int bad0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'(i * 17) ^ 8'h3C;
            exp_mem[i] = 8'(i * 17) ^ 8'h3C;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_psel", {31'd0, PSELx}, 32'd0);
        check("rst_penable", {31'd0, PENABLE}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_outs", {PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err}, 32'd0);
        PRESET = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: zero-wait write, cycle-accurate phases
        issue(1'b1, 4'h3, 8'hA5, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_setup_psel", {31'd0, PSELx}, 32'd1);
        check("t1_setup_penable", {31'd0, PENABLE}, 32'd0);
        check("t1_setup_bus", {19'd0, PWRITE, PADDR, PWDATA}, {19'd0, 1'b1, 4'h3, 8'hA5});
        check("t1_setup_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("t1_access", {30'd0, PSELx, PENABLE}, 32'd3);
        @(negedge clk);
        check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_back_idle", {30'd0, PSELx, PENABLE}, 32'd0);
        @(negedge clk);
        check("t1_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

        // 2: read with two wait states
        acc_seen = 0; bus_bad = 0;
        issue(1'b0, 4'h3, 8'h00, 2, 1'b0, 1'b0);
        wait_done();
        check("t2_access_cycles", acc_seen, 32'd3);
        check("t2_bus_stable", bus_bad, 32'd0);

        // 3: stuck PREADY aborts after TIMEOUT ACCESS cycles
        acc_seen = 0;
        issue(1'b0, 4'h5, 8'h00, 0, 1'b1, 1'b0);
        wait_done();
        check("t3_access_cycles", acc_seen, TO);
        issue(1'b1, 4'h6, 8'h77, 0, 1'b1, 1'b0);
        wait_done();
        issue(1'b0, 4'h6, 8'h00, 0, 1'b0, 1'b0);
        wait_done();
        acc_seen = 0;
        issue(1'b0, 4'hA, 8'h00, TO - 1, 1'b0, 1'b0);
        wait_done();
        check("t3_just_in_time", acc_seen, TO);

        // 4: reset during ACCESS
        issue(1'b0, 4'h7, 8'h00, 0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t4_in_access", {31'd0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        exp_q.delete(exp_q.size() - 1);
        push_cnt--;
        @(negedge clk);
        check("t4_rst_bus", {30'd0, PSELx, PENABLE}, 32'd0);
        check("t4_rst_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        PRESET = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check("t4_ready_after", {31'd0, cmd_ready}, 32'd1);
        issue(1'b1, 4'h7, 8'hC3, 0, 1'b0, 1'b0);
        issue(1'b0, 4'h7, 8'h00, 1, 1'b0, 1'b0);
        wait_done();

        // 5: back-to-back held cmd_valid, address extremes
        bus_bad = 0;
        issue(1'b1, 4'h0, 8'h11, 0, 1'b0, 1'b1);
        a0 = accept_cyc;
        issue(1'b1, 4'hF, 8'h22, 0, 1'b0, 1'b0);
        check("t5_gap", accept_cyc - a0, 32'd3);
        wait_done();
        check("t5_bus_stable", bus_bad, 32'd0);
        issue(1'b0, 4'h0, 8'h00, 0, 1'b0, 1'b0);
        issue(1'b0, 4'hF, 8'h00, 0, 1'b0, 1'b0);
        wait_done();

        // 6: TIMEOUT=0 instance never aborts
        @(negedge clk);
        c0_valid = 1'b1;
        for (int i = 0; i < 50 && !c0_ready; i++) @(negedge clk);
        check("t6_accept", {31'd0, c0_ready}, 32'd1);
        @(posedge clk);
        #1 c0_valid = 1'b0;
        bad0 = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (r0_valid) bad0++;
        end
        check("t6_no_abort", bad0, 32'd0);
        check("t6_still_access", {30'd0, psel0, penable0}, 32'd3);
        pready0 = 1'b1;
        @(negedge clk);
        pready0 = 1'b0;
        check("t6_rsp_valid", {31'd0, r0_valid}, 32'd1);
        check("t6_rsp_err", {31'd0, r0_err}, 32'd0);
        check("t6_rsp_rdata", {24'd0, r0_rdata}, 32'h5C);

        repeat (3) @(negedge clk);
        check("rsp_count", rsp_cnt, push_cnt);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
